// File: rtl/sd_crc_pkg.sv
// sd_crc_pkg: shared constants, FSM state type and the single-bit CRC step for the SD CRC engine
package sd_crc_pkg;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int CMD_MSG_W = 40;
  localparam int DAT_BLOCK_W = 4096;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  // Operates on a 16-bit container; bits at and above w are forced to zero.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din, input logic [15:0] poly, input int w);
    logic fb;
    logic [15:0] mask;
    fb = crc[w-1] ^ din;
    mask = 16'((32'd1 << w) - 32'd1);
    return ((crc << 1) ^ (fb ? poly : 16'h0)) & mask;
  endfunction
endpackage

// File: rtl/sd_crc_step_unit.sv
// sd_crc_step_unit: combinational BITS_PER_CYCLE-deep unrolled CRC update, MSB of bits applied first
module sd_crc_step_unit
  import sd_crc_pkg::*;
#(
  parameter int CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY = 7'h09,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [CRC_W-1:0]          crc_in,
  input  logic [BITS_PER_CYCLE-1:0] bits,
  output logic [CRC_W-1:0]          crc_out
);
  logic [CRC_W-1:0] acc;
  always_comb begin
    acc = crc_in;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--)
      acc = CRC_W'(crc_step(16'(acc), bits[i], 16'(POLY), CRC_W));
    crc_out = acc;
  end
endmodule

// File: rtl/sd_crc_engine.sv
// sd_crc_engine: bit-serial CRC generator with Start/Busy/Valid handshake.
// Define SD_CRC_CHECK_EN to add the RxCRC input and Match output for receive-side checking.
module sd_crc_engine
  import sd_crc_pkg::*;
#(
  parameter int CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY = 7'h09,
  parameter int MSG_W = 40,
  parameter int BITS_PER_CYCLE = 1,
  parameter logic [CRC_W-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [MSG_W-1:0] Message,
`ifdef SD_CRC_CHECK_EN
  input  logic [CRC_W-1:0] RxCRC,
`endif
  output logic             Busy,
  output logic             Valid,
  output logic [CRC_W-1:0] CRC
`ifdef SD_CRC_CHECK_EN
  ,
  output logic             Match
`endif
);
  localparam int BEATS = MSG_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(BEATS + 1);
  if (MSG_W % BITS_PER_CYCLE != 0) begin : g_err_msg_w
    $error("MSG_W must be a multiple of BITS_PER_CYCLE");
  end
  if (CRC_W < 1 || CRC_W > 16) begin : g_err_crc_w
    $error("CRC_W must be in 1..16");
  end
  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_err_bpc
    $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  state_t state, state_nx;
  logic accept;
  logic [MSG_W-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [CRC_W-1:0] crc_step_out;
  sd_crc_step_unit #(.CRC_W(CRC_W), .POLY(POLY), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .crc_in (CRC),
    .bits   (sr[MSG_W-1 -: BITS_PER_CYCLE]),
    .crc_out(crc_step_out)
  );
  // A request is taken from IDLE or DONE; while shifting it is dropped.
  always_comb begin
    accept = Start && state != SHIFT;
    state_nx = accept ? SHIFT : (state == SHIFT && cnt == CNT_W'(1)) ? DONE : state;
    Busy = state == SHIFT;
    Valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      CRC <= INIT;
    end else if (accept) begin
      sr <= Message;
      cnt <= CNT_W'(BEATS);
      CRC <= INIT;
    end else if (state == SHIFT) begin
      sr <= sr << BITS_PER_CYCLE;
      cnt <= cnt - CNT_W'(1);
      CRC <= crc_step_out;
    end
`ifdef SD_CRC_CHECK_EN
  logic [CRC_W-1:0] rx_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_q <= '0;
    else if (accept) rx_q <= RxCRC;
  assign Match = state == DONE && CRC == rx_q;
`endif
endmodule

// File: tb/tb_sd_crc_engine.sv
// tb_sd_crc_engine: table, random and corner-sequence checks of CRC7 (1 and 4 bits/cycle) and CRC16 (8 bits/cycle)
module tb_sd_crc_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start7 = 1'b0;
  logic [39:0] msg7 = '0;
  logic busy1, valid1, busy4, valid4;
  logic [6:0] crc1, crc4;
  logic start16 = 1'b0;
  logic [4095:0] msg16 = '0;
  logic busy16, valid16;
  logic [15:0] crc16;
`ifdef SD_CRC_CHECK_EN
  logic [6:0] rx7 = '0;
  logic [15:0] rx16 = '0;
  logic match1, match4, match16;
`endif
  int checks = 0;
  int fails = 0;

  sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .MSG_W(40), .BITS_PER_CYCLE(1), .INIT(7'h00)) d1 (
    .clk(clk), .rst_n(rst_n), .Start(start7), .Message(msg7),
`ifdef SD_CRC_CHECK_EN
    .RxCRC(rx7), .Match(match1),
`endif
    .Busy(busy1), .Valid(valid1), .CRC(crc1));
  sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .MSG_W(40), .BITS_PER_CYCLE(4), .INIT(7'h00)) d4 (
    .clk(clk), .rst_n(rst_n), .Start(start7), .Message(msg7),
`ifdef SD_CRC_CHECK_EN
    .RxCRC(rx7), .Match(match4),
`endif
    .Busy(busy4), .Valid(valid4), .CRC(crc4));
  sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .MSG_W(4096), .BITS_PER_CYCLE(8), .INIT(16'h0000)) d16 (
    .clk(clk), .rst_n(rst_n), .Start(start16), .Message(msg16),
`ifdef SD_CRC_CHECK_EN
    .RxCRC(rx16), .Match(match16),
`endif
    .Busy(busy16), .Valid(valid16), .CRC(crc16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: remainder of M(x)*x^W divided by the full generator polynomial (long division).
  function automatic logic [6:0] ref7(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [15:0] ref16(input logic [4095:0] m);
    logic [4111:0] v;
    v = {m, 16'b0};
    for (int i = 4111; i >= 16; i--)
      if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h11021;
    return v[15:0];
  endfunction

  // Cycle 0 = cycle with Start high; cycle c = after the c-th following rising edge.
  task automatic run7(input logic [39:0] m, input logic [6:0] exp, input string name, input int inject_at);
    int f1, f4;
    f1 = 0;
    f4 = 0;
    msg7 = m;
    start7 = 1'b1;
    @(posedge clk); #1;
    start7 = 1'b0;
    msg7 = ~m;
    check({name, " busy1"}, busy1, 1);
    check({name, " busy4"}, busy4, 1);
    for (int c = 1; c <= 50; c++) begin
      if (valid1 && f1 == 0) f1 = c;
      if (valid4 && f4 == 0) f4 = c;
      start7 = c == inject_at;
      if (c == inject_at) msg7 = 40'h77_0000_0000;
      @(posedge clk); #1;
    end
    check({name, " lat1"}, f1, 41);
    check({name, " lat4"}, f4, 11);
    check({name, " crc1"}, crc1, exp);
    check({name, " crc4"}, crc4, exp);
    check({name, " hold"}, {busy1, valid1, busy4, valid4}, 4'b0101);
  endtask

  task automatic run16(input logic [4095:0] m, input logic [15:0] exp, input string name);
    int f;
    f = 0;
    msg16 = m;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    msg16 = ~m;
    for (int c = 1; c <= 520; c++) begin
      if (valid16 && f == 0) f = c;
      @(posedge clk); #1;
    end
    check({name, " lat"}, f, 513);
    check({name, " crc"}, crc16, exp);
  endtask

  typedef struct {
    logic [39:0] msg;
    logic [6:0] crc;
  } vec_t;
  vec_t tbl[4];

  initial begin
    logic [39:0] rm;
    logic [4095:0] blk;
    tbl[0] = '{40'h40_0000_0000, 7'b1001010};
    tbl[1] = '{40'h48_0000_01AA, 7'b1000011};
    tbl[2] = '{40'h77_0000_0000, 7'b0110010};
    tbl[3] = '{40'h51_0000_0000, 7'h2A};
    #22;
    check("reset busy/valid", {busy1, valid1, busy4, valid4, busy16, valid16}, 6'b0);
    check("reset crc7", {crc1, crc4}, 14'h0);
    check("reset crc16", crc16, 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) run7(tbl[i].msg, tbl[i].crc, $sformatf("tbl%0d", i), 0);
    for (int i = 0; i < 12; i++) begin
      rm = {$urandom, $urandom_range(255, 0)};
      run7(rm, ref7(rm), $sformatf("rnd%0d", i), 0);
    end
    run7(40'h48_0000_01AA, 7'h43, "ignored start", 10);
    // Reset in the middle of a computation, then a clean CMD0.
    msg7 = 40'h40_0000_0000;
    start7 = 1'b1;
    @(posedge clk); #1;
    start7 = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("pre-reset busy1", busy1, 1);
    rst_n = 1'b0;
    #1;
    check("abort flags", {busy1, valid1, busy4, valid4}, 4'b0);
    check("abort crc", {crc1, crc4}, 14'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run7(40'h40_0000_0000, 7'h4A, "post-reset cmd0", 0);
`ifdef SD_CRC_CHECK_EN
    rx7 = 7'h4A;
    run7(40'h40_0000_0000, 7'h4A, "match cmd0", 0);
    check("match ok", {match1, match4}, 2'b11);
    rx7 = 7'h4B;
    run7(40'h40_0000_0000, 7'h4A, "mismatch cmd0", 0);
    check("match bad", {match1, match4, valid1, valid4}, 4'b0011);
`endif
    run16({4096{1'b1}}, 16'h7FA1, "dat ff");
    for (int i = 0; i < 128; i++) blk[i*32 +: 32] = $urandom;
    run16(blk, ref16(blk), "dat rnd");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
